// File: rtl/noc_pkt_rate_buffer.sv
// Packet-aware flit FIFO that releases whole packets (or cut-through oversize ones)
// and forces GAP_CYCLES idle cycles after each tail. Optional macro: NOC_PKT_CODE_CHECK_EN.
module noc_pkt_rate_buffer #(
    parameter int          DATA_WIDTH  = 128,
    parameter int          DEPTH       = 16,
    parameter int          GAP_CYCLES  = 4,
    parameter logic [3:0]  TAIL_CODE_H = 4'hC,
    parameter logic [3:0]  TAIL_CODE_E = 4'hD,
    parameter int          TAIL_E_LSB  = 56
) (
    input  logic                          noc_clk,
    input  logic                          noc_rst,
    input  logic [DATA_WIDTH:0]           in_data,
    input  logic                          in_head,
    input  logic                          in_tail,
    output logic                          buf_full,
    input  logic                          out_ready,
    output logic [DATA_WIDTH:0]           out_data,
    output logic                          out_head,
    output logic                          out_tail,
    output logic [$clog2(DEPTH):0]        pkt_cnt,
    output logic [$clog2(DEPTH):0]        flit_cnt,
    output logic                          ovf_err,
    output logic                          code_err,
    output logic [1:0]                    state_dbg
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_WIDTH + 2;
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

    // Entry layout: {flit, head, eff_tail}
    logic [ENT_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      flit_cnt_q, flit_cnt_d, pkt_cnt_q, pkt_cnt_d;
    logic                  buf_full_q, buf_full_d;
    logic                  ovf_err_q, ovf_err_d, code_err_q, code_err_d;
    logic [DATA_WIDTH:0]   out_data_q, out_data_d;
    logic                  out_head_q, out_head_d, out_tail_q, out_tail_d;
    state_t                state_q, state_d;
    logic [3:0]            gap_cnt_q, gap_cnt_d;
    logic                  in_valid, wr_en, pop, eff_tail, rd_head, rd_tail;
    logic [ENT_W-1:0]      rd_entry;

    assign in_valid = in_data[DATA_WIDTH];
    assign wr_en    = in_valid && !buf_full_q;
    assign rd_entry = mem[rd_ptr_q];
    assign rd_head  = rd_entry[1];
    assign rd_tail  = rd_entry[0];
    assign pop      = (state_q == SEND) && out_ready && (flit_cnt_q != '0);

`ifdef NOC_PKT_CODE_CHECK_EN
    logic code_ok;
    assign code_ok    = (in_data[DATA_WIDTH-1 -: 4] == TAIL_CODE_H) &&
                        (in_data[TAIL_E_LSB +: 4] == TAIL_CODE_E);
    assign eff_tail   = in_tail && code_ok;
    assign code_err_d = code_err_q || (wr_en && in_tail && !code_ok);
`else
    assign eff_tail   = in_tail;
    assign code_err_d = 1'b0;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
        flit_cnt_d = flit_cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
        pkt_cnt_d  = pkt_cnt_q + CNT_W'(wr_en && eff_tail) - CNT_W'(pop && rd_tail);
        buf_full_d = (flit_cnt_d == CNT_W'(DEPTH));
        ovf_err_d  = ovf_err_q || (in_valid && buf_full_q);
        // Valid bit drops on non-pop cycles while the payload holds.
        out_data_d = {pop, pop ? rd_entry[ENT_W-1:2] : out_data_q[DATA_WIDTH-1:0]};
        out_head_d = pop ? rd_head : out_head_q;
        out_tail_d = pop ? rd_tail : out_tail_q;
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                // Full with no complete packet means an oversize packet: cut through.
                if (pkt_cnt_q != '0 || (buf_full_q && pkt_cnt_q == '0)) state_d = SEND;
            end
            SEND: begin
                if (pop && rd_tail) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) state_d = IDLE;
                else                   gap_cnt_d = gap_cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            buf_full_q <= 1'b0;
            ovf_err_q  <= 1'b0;
            code_err_q <= 1'b0;
            out_data_q <= '0;
            out_head_q <= 1'b0;
            out_tail_q <= 1'b0;
            state_q    <= IDLE;
            gap_cnt_q  <= 4'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            buf_full_q <= buf_full_d;
            ovf_err_q  <= ovf_err_d;
            code_err_q <= code_err_d;
            out_data_q <= out_data_d;
            out_head_q <= out_head_d;
            out_tail_q <= out_tail_d;
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge noc_clk) begin
        if (wr_en) mem[wr_ptr_q] <= {in_data[DATA_WIDTH-1:0], in_head, eff_tail};
    end

    assign buf_full  = buf_full_q;
    assign out_data  = out_data_q;
    assign out_head  = out_head_q && out_data_q[DATA_WIDTH];
    assign out_tail  = out_tail_q && out_data_q[DATA_WIDTH];
    assign pkt_cnt   = pkt_cnt_q;
    assign flit_cnt  = flit_cnt_q;
    assign ovf_err   = ovf_err_q;
    assign code_err  = code_err_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_noc_pkt_rate_buffer.sv
// Directed bench for noc_pkt_rate_buffer (default parameters); expectations are hand-computed.
module tb_noc_pkt_rate_buffer;
    localparam int DW = 128;
    localparam int CW = 5;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic          noc_clk = 1'b0;
    logic          noc_rst;
    logic [DW:0]   in_data;
    logic          in_head, in_tail, out_ready;
    logic          buf_full, out_head, out_tail, ovf_err, code_err;
    logic [DW:0]   out_data;
    logic [CW-1:0] pkt_cnt, flit_cnt;
    logic [1:0]    state_dbg;

    int checks   = 0;
    int failures = 0;

    noc_pkt_rate_buffer dut (
        .noc_clk(noc_clk), .noc_rst(noc_rst), .in_data(in_data),
        .in_head(in_head), .in_tail(in_tail), .buf_full(buf_full),
        .out_ready(out_ready), .out_data(out_data), .out_head(out_head),
        .out_tail(out_tail), .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt),
        .ovf_err(ovf_err), .code_err(code_err), .state_dbg(state_dbg)
    );

    always #5 noc_clk = ~noc_clk;

    task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] flit(input logic [3:0] ch, input logic [15:0] idx);
        logic [DW-1:0] f;
        f = '0;
        f[DW-1 -: 4] = ch;
        f[56 +: 4]   = 4'hD;
        f[15:0]      = idx;
        return f;
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] f, input logic h, input logic t);
        in_data = {v, f};
        in_head = h;
        in_tail = t;
    endtask

    task automatic tick();
        @(posedge noc_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        noc_rst = 1'b1; in_data = '0; in_head = 1'b0; in_tail = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge noc_clk);
        #1;
        check("rst_out_data", out_data, '0);
        check("rst_buf_full", buf_full, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_flit_cnt", flit_cnt, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_code_err", code_err, 0);
        check("rst_state", state_dbg, S_IDLE);
        noc_rst = 1'b0;
        tick();

        // 3-flit packet, out_ready high: first flit two edges after tail store
        out_ready = 1'b1;
        drive(1, flit(4'hC, 16'h11), 1, 0); tick();
        check("p1_flit_cnt1", flit_cnt, 1);
        check("p1_state_idle", state_dbg, S_IDLE);
        drive(1, flit(4'hC, 16'h12), 0, 0); tick();
        drive(1, flit(4'hC, 16'h13), 0, 1); tick();
        check("p1_pkt_cnt1", pkt_cnt, 1);
        check("p1_flit_cnt3", flit_cnt, 3);
        check("p1_state_e", state_dbg, S_IDLE);
        drive(0, '0, 0, 0); tick();
        check("p1_state_send", state_dbg, S_SEND);
        check("p1_e1_valid", out_data[DW], 0);
        tick();
        check("p1_f0", out_data, {1'b1, flit(4'hC, 16'h11)});
        check("p1_f0_head", out_head, 1);
        check("p1_f0_tail", out_tail, 0);
        tick();
        check("p1_f1", out_data, {1'b1, flit(4'hC, 16'h12)});
        check("p1_f1_head", out_head, 0);
        tick();
        check("p1_f2", out_data, {1'b1, flit(4'hC, 16'h13)});
        check("p1_f2_tail", out_tail, 1);
        check("p1_pkt_cnt0", pkt_cnt, 0);
        check("p1_flit_cnt0", flit_cnt, 0);
        check("p1_state_gap", state_dbg, S_GAP);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("p1_gap_valid", out_data[DW], 0);
            check("p1_gap_tail", out_tail, 0);
            check("p1_gap_state", state_dbg, (i < 3) ? S_GAP : S_IDLE);
        end
        check("p1_payload_hold", out_data, {1'b0, flit(4'hC, 16'h13)});

        // Two back-to-back 2-flit packets with out_ready toggling
        out_ready = 1'b0;
        drive(1, flit(4'hC, 16'h21), 1, 0); tick();
        drive(1, flit(4'hC, 16'h22), 0, 1); tick();
        drive(1, flit(4'hC, 16'h23), 1, 0); tick();
        drive(1, flit(4'hC, 16'h24), 0, 1); tick();
        drive(0, '0, 0, 0);
        check("p2_pkt_cnt2", pkt_cnt, 2);
        check("p2_flit_cnt4", flit_cnt, 4);
        check("p2_state_send", state_dbg, S_SEND);
        out_ready = 1'b1; tick();
        check("p2_a0", out_data, {1'b1, flit(4'hC, 16'h21)});
        check("p2_a0_head", out_head, 1);
        out_ready = 1'b0; tick();
        check("p2_stall_valid", out_data, {1'b0, flit(4'hC, 16'h21)});
        out_ready = 1'b1; tick();
        check("p2_a1", out_data, {1'b1, flit(4'hC, 16'h22)});
        check("p2_a1_tail", out_tail, 1);
        check("p2_pkt_cnt1", pkt_cnt, 1);
        check("p2_state_gap", state_dbg, S_GAP);
        for (int k = 1; k <= 8; k++) begin
            out_ready = (k % 2 == 0);
            tick();
            check("p2_valid_seq", out_data[DW], (k == 6 || k == 8));
            if (k == 6) begin
                check("p2_b0", out_data, {1'b1, flit(4'hC, 16'h23)});
                check("p2_b0_head", out_head, 1);
            end
            if (k == 8) begin
                check("p2_b1", out_data, {1'b1, flit(4'hC, 16'h24)});
                check("p2_b1_tail", out_tail, 1);
            end
        end
        check("p2_pkt_cnt0", pkt_cnt, 0);
        check("p2_flit_cnt0", flit_cnt, 0);
        out_ready = 1'b0;
        repeat (4) tick();
        check("p2_state_idle", state_dbg, S_IDLE);

        // Tail write coincides with tail pop
        drive(1, flit(4'hC, 16'h31), 1, 0); tick();
        drive(1, flit(4'hC, 16'h32), 0, 1); tick();
        drive(1, flit(4'hC, 16'h41), 1, 0); tick();
        check("p3_state_send", state_dbg, S_SEND);
        check("p3_flit_cnt3", flit_cnt, 3);
        out_ready = 1'b1;
        drive(1, flit(4'hC, 16'h42), 0, 0); tick();
        check("p3_c0", out_data, {1'b1, flit(4'hC, 16'h31)});
        check("p3_flit_hold", flit_cnt, 3);
        drive(1, flit(4'hC, 16'h43), 0, 1); tick();
        check("p3_c1", out_data, {1'b1, flit(4'hC, 16'h32)});
        check("p3_pkt_hold", pkt_cnt, 1);
        check("p3_flit_hold2", flit_cnt, 3);
        check("p3_state_gap", state_dbg, S_GAP);
        drive(0, '0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("p3_gap_valid", out_data[DW], 0);
        end
        check("p3_state_send2", state_dbg, S_SEND);
        tick();
        check("p3_d0", out_data, {1'b1, flit(4'hC, 16'h41)});
        tick();
        check("p3_d1", out_data, {1'b1, flit(4'hC, 16'h42)});
        tick();
        check("p3_d2", out_data, {1'b1, flit(4'hC, 16'h43)});
        check("p3_d2_tail", out_tail, 1);
        check("p3_pkt_cnt0", pkt_cnt, 0);
        out_ready = 1'b0;
        repeat (5) tick();
        check("p3_state_idle", state_dbg, S_IDLE);

        // Oversize packet: 17 writes, no tail
        for (int i = 0; i < 16; i++) begin
            drive(1, flit(4'hC, 16'h50 + 16'(i)), (i == 0), 0);
            tick();
        end
        check("p4_flit_cnt16", flit_cnt, 16);
        check("p4_buf_full", buf_full, 1);
        check("p4_ovf0", ovf_err, 0);
        check("p4_state_idle", state_dbg, S_IDLE);
        drive(1, flit(4'hC, 16'h60), 0, 0); tick();
        check("p4_ovf1", ovf_err, 1);
        check("p4_flit_cap", flit_cnt, 16);
        check("p4_state_send", state_dbg, S_SEND);
        drive(0, '0, 0, 0);
        out_ready = 1'b1; tick();
        check("p4_ct0", out_data, {1'b1, flit(4'hC, 16'h50)});
        check("p4_flit15", flit_cnt, 15);
        check("p4_not_full", buf_full, 0);
        tick();
        check("p4_ct1", out_data, {1'b1, flit(4'hC, 16'h51)});
        check("p4_ovf_sticky", ovf_err, 1);

        // Asynchronous reset between edges
        noc_rst = 1'b1; #2;
        check("r1_out_data", out_data, '0);
        check("r1_flit_cnt", flit_cnt, 0);
        check("r1_buf_full", buf_full, 0);
        check("r1_ovf", ovf_err, 0);
        check("r1_state", state_dbg, S_IDLE);
        @(posedge noc_clk); #1;
        noc_rst = 1'b0;

        // Reset during SEND of flit 2 of 4
        out_ready = 1'b1;
        drive(1, flit(4'hC, 16'h71), 1, 0); tick();
        drive(1, flit(4'hC, 16'h72), 0, 0); tick();
        drive(1, flit(4'hC, 16'h73), 0, 0); tick();
        drive(1, flit(4'hC, 16'h74), 0, 1); tick();
        drive(0, '0, 0, 0);
        tick();
        tick();
        check("p5_f0", out_data, {1'b1, flit(4'hC, 16'h71)});
        tick();
        check("p5_f1", out_data, {1'b1, flit(4'hC, 16'h72)});
        #2 noc_rst = 1'b1;
        #1;
        check("p5_rst_out", out_data, '0);
        check("p5_rst_head", out_head, 0);
        check("p5_rst_tail", out_tail, 0);
        check("p5_rst_pkt", pkt_cnt, 0);
        check("p5_rst_flit", flit_cnt, 0);
        check("p5_rst_state", state_dbg, S_IDLE);
        @(posedge noc_clk); #1;
        noc_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("p5_post_out", out_data, '0);
            check("p5_post_state", state_dbg, S_IDLE);
        end

        // Tail flit with a bad head code
        drive(1, flit(4'hA, 16'h81), 1, 1); tick();
        drive(0, '0, 0, 0);
`ifdef NOC_PKT_CODE_CHECK_EN
        check("p6_code_err", code_err, 1);
        check("p6_pkt_cnt0", pkt_cnt, 0);
        check("p6_flit_cnt1", flit_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p6_no_out", out_data[DW], 0);
            check("p6_state_idle", state_dbg, S_IDLE);
        end
`else
        check("p6_code_err", code_err, 0);
        check("p6_pkt_cnt1", pkt_cnt, 1);
        check("p6_flit_cnt1", flit_cnt, 1);
        tick();
        tick();
        check("p6_out", out_data, {1'b1, flit(4'hA, 16'h81)});
        check("p6_head", out_head, 1);
        check("p6_tail", out_tail, 1);
        check("p6_pkt_cnt0", pkt_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
